// File: rtl/seq_ctrl_if.sv
// Bus bundle between the sequencer and its datapath/memories.
// The master drives instruction, memory and flag inputs; the slave returns strobes and status.
interface seq_ctrl_if;
  logic        START;
  logic [15:0] INSTR;
  logic        IMEM_RDY;
  logic        DMEM_ACK;
  logic        Z_FLAG;
  logic        PC_RST;
  logic        PC_INC;
  logic        BRANCH;
  logic [7:0]  ADDR_OUT;
  logic        IMEM_RD;
  logic        IR_LOAD;
  logic        ALU_EN;
  logic        DMEM_RD;
  logic        DMEM_WR;
  logic        BUSY;
  logic        HALTED;
  logic        ERR;
  logic        ILLEGAL;
  logic [2:0]  STATE;

  modport master (
    output START, INSTR, IMEM_RDY, DMEM_ACK, Z_FLAG,
    input  PC_RST, PC_INC, BRANCH, ADDR_OUT, IMEM_RD, IR_LOAD, ALU_EN,
           DMEM_RD, DMEM_WR, BUSY, HALTED, ERR, ILLEGAL, STATE
  );

  modport slave (
    input  START, INSTR, IMEM_RDY, DMEM_ACK, Z_FLAG,
    output PC_RST, PC_INC, BRANCH, ADDR_OUT, IMEM_RD, IR_LOAD, ALU_EN,
           DMEM_RD, DMEM_WR, BUSY, HALTED, ERR, ILLEGAL, STATE
  );
endinterface

// File: rtl/seq_ctrl.sv
// Instruction sequencer: fetch/decode/execute control with a data-memory wait timeout.
// Strobes are decoded combinationally from the state, the latched instruction and live inputs.
module seq_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic      clk,
  input  logic      RST_N,
  seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ALU   = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_JMP   = 4'h4;
  localparam logic [3:0] OP_JZ    = 4'h5;
  localparam logic [3:0] OP_JNZ   = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // The last wait cycle is the one where the counter already holds MEM_TIMEOUT-1.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  logic [3:0] ir_op;
  logic [7:0] ir_arg;
  logic [7:0] wait_cnt;
  logic       err_q;
  logic       ill_q;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      ir_op    <= 4'h0;
      ir_arg   <= 8'h00;
      wait_cnt <= 8'h00;
      err_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (bus.START) begin
            state <= S_FETCH;
            err_q <= 1'b0;
            ill_q <= 1'b0;
          end
        end
        S_FETCH: begin
          if (bus.IMEM_RDY) begin
            ir_op  <= bus.INSTR[15:12];
            ir_arg <= bus.INSTR[7:0];
            state  <= S_DECODE;
          end
        end
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          case (ir_op)
            OP_LOAD, OP_STORE: begin
              state    <= S_MEM;
              wait_cnt <= 8'h00;
            end
            OP_HALT: state <= S_HALT;
            OP_NOP, OP_ALU, OP_JMP, OP_JZ, OP_JNZ: state <= S_FETCH;
            default: begin
              ill_q <= 1'b1;
              state <= S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          // An acknowledge on the final wait cycle still completes the access.
          if (bus.DMEM_ACK) begin
            state <= S_FETCH;
          end else if (wait_cnt == WAIT_LAST) begin
            err_q <= 1'b1;
            state <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic pc_rst, pc_inc, branch, imem_rd, ir_load, alu_en, dmem_rd, dmem_wr;

  always_comb begin
    pc_rst  = 1'b0;
    pc_inc  = 1'b0;
    branch  = 1'b0;
    imem_rd = 1'b0;
    ir_load = 1'b0;
    alu_en  = 1'b0;
    dmem_rd = 1'b0;
    dmem_wr = 1'b0;
    case (state)
      // START may be high while reset is held, so the pulse is gated by RST_N.
      S_IDLE, S_HALT: pc_rst = bus.START & RST_N;
      S_FETCH: begin
        imem_rd = 1'b1;
        ir_load = bus.IMEM_RDY;
      end
      S_EXEC: begin
        case (ir_op)
          OP_ALU: begin
            alu_en = 1'b1;
            pc_inc = 1'b1;
          end
          OP_LOAD, OP_STORE, OP_HALT: ;
          OP_JMP: branch = 1'b1;
          OP_JZ: begin
            branch = bus.Z_FLAG;
            pc_inc = ~bus.Z_FLAG;
          end
          OP_JNZ: begin
            branch = ~bus.Z_FLAG;
            pc_inc = bus.Z_FLAG;
          end
          default: pc_inc = 1'b1;
        endcase
      end
      S_MEM: begin
        dmem_rd = (ir_op == OP_LOAD);
        dmem_wr = (ir_op == OP_STORE);
        pc_inc  = bus.DMEM_ACK;
      end
      default: ;
    endcase
  end

  assign bus.PC_RST   = pc_rst;
  assign bus.PC_INC   = pc_inc;
  assign bus.BRANCH   = branch;
  assign bus.ADDR_OUT = ir_arg;
  assign bus.IMEM_RD  = imem_rd;
  assign bus.IR_LOAD  = ir_load;
  assign bus.ALU_EN   = alu_en;
  assign bus.DMEM_RD  = dmem_rd;
  assign bus.DMEM_WR  = dmem_wr;
  assign bus.BUSY     = (state == S_FETCH) || (state == S_DECODE) ||
                        (state == S_EXEC)  || (state == S_MEM);
  assign bus.HALTED   = (state == S_HALT);
  assign bus.ERR      = err_q;
  assign bus.ILLEGAL  = ill_q;
  assign bus.STATE    = state;

endmodule

// File: doc/seq_ctrl.md
SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, max DMEM wait cycles before error (1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port START  input  1  begin execution from address 0 (sampled in IDLE/HALT only).
REQ-005 SHALL have port INSTR  input  16  instruction word; opcode INSTR[15:12], operand INSTR[7:0].
REQ-006 SHALL have port IMEM_RDY  input  1  instruction memory data valid.
REQ-007 SHALL have port DMEM_ACK  input  1  data memory access complete.
REQ-008 SHALL have port Z_FLAG  input  1  ALU zero flag.
REQ-009 SHALL have port PC_RST  output  1  one-cycle pulse clearing program counter.
REQ-010 SHALL have port PC_INC  output  1  one-cycle pulse advancing PC by 1.
REQ-011 SHALL have port BRANCH  output  1  one-cycle pulse loading PC from ADDR_OUT.
REQ-012 SHALL have port ADDR_OUT  output  8  branch target.
REQ-013 SHALL have ports IMEM_RD, IR_LOAD, ALU_EN, DMEM_RD, DMEM_WR  output  1 each  datapath strobes.
REQ-014 SHALL have ports BUSY, HALTED, ERR, ILLEGAL  output  1 each  status; STATE  output  3  current state.

Function
REQ-015 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, HALT=5; codes 6,7 unreachable, recover to IDLE.
REQ-016 IDLE/HALT: START=1 -> PC_RST pulse same cycle, next state FETCH; else remain.
REQ-017 FETCH: IMEM_RD=1 every cycle; IMEM_RDY=1 -> IR_LOAD pulse, instruction latched into internal IR, next DECODE; else stay.
REQ-018 DECODE: exactly one cycle, no strobes, next EXEC.
REQ-019 EXEC opcode 0x0 NOP: PC_INC pulse, next FETCH.
REQ-020 EXEC opcode 0x1 ALU: ALU_EN and PC_INC pulse same cycle, next FETCH.
REQ-021 EXEC opcode 0x2 LOAD / 0x3 STORE: next MEM, wait counter cleared; DMEM_RD (LOAD) or DMEM_WR (STORE) held high for every MEM cycle.
REQ-022 MEM: DMEM_ACK=1 -> strobe drops next cycle, PC_INC pulse, next FETCH.
REQ-023 MEM: counter increments each cycle without ACK; reaching MEM_TIMEOUT -> ERR set (sticky), next HALT, no PC_INC.
REQ-024 EXEC opcode 0x4 JMP: BRANCH pulse, ADDR_OUT=IR[7:0], next FETCH.
REQ-025 EXEC opcode 0x5 JZ / 0x6 JNZ: Z_FLAG sampled in EXEC; taken -> BRANCH pulse with ADDR_OUT=IR[7:0]; not taken -> PC_INC pulse; next FETCH.
REQ-026 EXEC opcode 0xF HALT: no PC pulse, next HALT.
REQ-027 EXEC other opcodes: treated as NOP, ILLEGAL set (sticky).
REQ-028 PC_INC, BRANCH, PC_RST SHALL be mutually exclusive every cycle.
REQ-029 ADDR_OUT SHALL equal IR[7:0] at all times after first IR_LOAD.
REQ-030 BUSY=1 in FETCH, DECODE, EXEC, MEM; HALTED=1 only in HALT.
REQ-031 ERR and ILLEGAL cleared only by reset or by START accepted in HALT/IDLE.
REQ-032 Strobes/status SHALL be decoded combinationally from STATE, IR and inputs (Mealy for IR_LOAD, PC_INC in MEM).

Reset
REQ-033 RST_N=0 SHALL immediately force IDLE, IR=0, wait counter=0, ERR=0, ILLEGAL=0, all strobes 0, BUSY=0, HALTED=0, STATE=0, regardless of clock.
REQ-034 Reset asserted mid-FETCH or mid-MEM SHALL abort the access with no PC pulse; after release, remain IDLE until START.

Verification
REQ-035 Reset, START, INSTR=0x1000 with IMEM_RDY after 2 cycles -> PC_RST 1 cycle, IR_LOAD, DECODE, EXEC with ALU_EN+PC_INC, back to FETCH; 1 PC_INC total.
REQ-036 INSTR=0x5042, Z_FLAG=1 -> BRANCH pulse, ADDR_OUT=0x42; repeat Z_FLAG=0 -> PC_INC, no BRANCH; JNZ inverse.
REQ-037 INSTR=0x2000, DMEM_ACK after 3 MEM cycles -> DMEM_RD high exactly 4 cycles, one PC_INC, ERR=0.
REQ-038 MEM_TIMEOUT=4, INSTR=0x3000, DMEM_ACK never -> DMEM_WR 4 cycles, ERR=1, HALTED=1, no PC_INC; START clears ERR.
REQ-039 INSTR=0x9000 -> ILLEGAL=1, PC_INC; INSTR=0xF000 -> HALTED=1, BUSY=0, stays until START.
REQ-040 RST_N low between clock edges during MEM -> STATE=0 and DMEM_RD=0 before next edge.
